// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one ALU between two valid/ready requesters.
// Optional statistics counters: define ALU_REQ_SCHEDULER_STATS_EN.
module alu_req_scheduler #(
    parameter int DATA_W = 5,
    parameter int RES_W  = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [6:0]        req0_cmd,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [6:0]        req1_cmd,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [RES_W-1:0]  rsp_data,
    output logic              rsp_err,
    output logic [DATA_W-1:0] alu_A,
    output logic [DATA_W-1:0] alu_B,
    output logic              alu_a_en,
    output logic              alu_b_en,
    output logic [2:0]        alu_a_op,
    output logic [1:0]        alu_b_op,
    output logic              alu_en,
    input  logic [RES_W-1:0]  alu_c,
    output logic [CNT_W-1:0]  stat_grant0,
    output logic [CNT_W-1:0]  stat_grant1,
    output logic [CNT_W-1:0]  stat_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t            state_q, state_d;
    logic              rr_q, rr_d;
    logic              id_q, id_d;
    logic [RES_W-1:0]  data_q, data_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [6:0]        cmd_q, cmd_d;

    logic              gnt1;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic [6:0]        sel_cmd;
    logic              rdy0, rdy1, en_raw, vld_raw;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        data_d  = data_q;
        err_d   = err_q;
        a_d     = a_q;
        b_d     = b_q;
        cmd_d   = cmd_q;
        rdy0    = 1'b0;
        rdy1    = 1'b0;
        en_raw  = 1'b0;
        vld_raw = 1'b0;
        // preferred requester wins if valid, otherwise the other one
        gnt1    = rr_q ? req1_valid : !req0_valid;
        sel_a   = gnt1 ? req1_a : req0_a;
        sel_b   = gnt1 ? req1_b : req0_b;
        sel_cmd = gnt1 ? req1_cmd : req0_cmd;
        unique case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    rdy0 = !gnt1;
                    rdy1 = gnt1;
                    id_d = gnt1;
                    if (sel_cmd[6:5] == 2'b00) begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        a_d     = sel_a;
                        b_d     = sel_b;
                        cmd_d   = sel_cmd;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                en_raw  = 1'b1;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                data_d  = alu_c;
                err_d   = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                vld_raw = 1'b1;
                if (rsp_ready) begin
                    rr_d    = !id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            id_q    <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            data_q  <= data_d;
            err_q   <= err_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cmd_q   <= cmd_d;
        end
    end

    // handshake outputs are silenced while reset is held
    assign req0_ready = rdy0 & rst_n;
    assign req1_ready = rdy1 & rst_n;
    assign alu_en     = en_raw & rst_n;
    assign rsp_valid  = vld_raw & rst_n;
    assign rsp_id     = id_q;
    assign rsp_data   = data_q;
    assign rsp_err    = err_q;
    assign alu_A      = a_q;
    assign alu_B      = b_q;
    assign alu_a_en   = cmd_q[6];
    assign alu_b_en   = cmd_q[5];
    assign alu_a_op   = cmd_q[4:2];
    assign alu_b_op   = cmd_q[1:0];

`ifdef ALU_REQ_SCHEDULER_STATS_EN
    logic [CNT_W-1:0] g0_q, g1_q, busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            g0_q   <= '0;
            g1_q   <= '0;
            busy_q <= '0;
        end else begin
            if (req0_valid && rdy0 && g0_q != '1)
                g0_q <= g0_q + CNT_W'(1);
            if (req1_valid && rdy1 && g1_q != '1)
                g1_q <= g1_q + CNT_W'(1);
            if (state_q != IDLE && busy_q != '1)
                busy_q <= busy_q + CNT_W'(1);
        end
    end

    assign stat_grant0 = g0_q;
    assign stat_grant1 = g1_q;
    assign stat_busy   = busy_q;
`else
    assign stat_grant0 = '0;
    assign stat_grant1 = '0;
    assign stat_busy   = '0;
`endif

endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
Shares one ALU datapath instance between two requesters using round-robin arbitration. Each request is a valid/ready transaction carrying operands and an opcode bundle. The scheduler sequences one ALU operation at a time: it accepts a request, drives the ALU enables for one cycle, captures the registered ALU result and returns it on a response channel with valid/ready backpressure. It sits between the ALU and its clients.

Parameters:
DATA_W, 5, operand width; signed two's complement; matches ALU A/B.
RES_W, 6, result width; signed; matches ALU c.
CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
clk  input  1  clock; all logic on the rising edge.
rst_n  input  1  reset; synchronous, active-low.
req0_valid / req1_valid  input  1  requester has a command pending.
req0_ready / req1_ready  output  1  one-cycle accept pulse; transfer occurs when valid&&ready.
req0_a / req1_a  input  DATA_W  operand A.
req0_b / req1_b  input  DATA_W  operand B.
req0_cmd / req1_cmd  input  7  {a_en, b_en, a_op[2:0], b_op[1:0]}.
rsp_valid  output  1  response available.
rsp_ready  input  1  consumer accepts the response.
rsp_id  output  1  requester index of the response.
rsp_data  output  RES_W  ALU result.
rsp_err  output  1  command had a_en=b_en=0; not issued to the ALU.
alu_A / alu_B  output  DATA_W  operands to the ALU.
alu_a_en / alu_b_en  output  1  ALU mode enables.
alu_a_op  output  3  ALU a_op.
alu_b_op  output  2  ALU b_op.
alu_en  output  1  ALU_en; high for exactly one cycle per issued op.
alu_c  input  RES_W  registered ALU result.
stat_grant0 / stat_grant1 / stat_busy  output  CNT_W  statistics counters (see Optional Feature).

Behaviour:
- Reset (rst_n low at a clock edge): state=IDLE; rr_ptr=0 (requester 0 preferred); all outputs 0, including ready, alu_*, and rsp_*. Reset asserted mid-operation aborts the operation: no response, no ready pulse. An ALU result already in flight is discarded.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: if no valid input, stay in IDLE. Otherwise grant the requester selected by rr_ptr if it is valid, else the other one.
  - Pulse reqN_ready for that cycle.
  - Latch a, b and cmd into internal registers, and latch id.
  - If cmd a_en=b_en=0, go to RESP with rsp_data=0 and rsp_err=1. The ALU is not touched.
  - Otherwise go to ISSUE.
- ISSUE: drive alu_A/B/a_en/b_en/a_op/b_op from the latched values and set alu_en=1 for this one cycle, then go to CAPTURE.
- CAPTURE: the ALU has registered c at the ISSUE edge. Latch alu_c into rsp_data, set rsp_err=0, go to RESP.
- RESP: hold rsp_valid=1 and keep rsp_id, rsp_data and rsp_err stable until rsp_ready=1.
  - On the handshake cycle, set rr_ptr to the inverse of the served id and go to IDLE.
  - rsp_valid drops on the next cycle.
  - No new request is accepted while in ISSUE, CAPTURE or RESP.
- alu_A/B/enables/ops hold their last driven values when not in ISSUE. alu_en is 0 outside ISSUE.
- Latency: ready pulse at cycle T; earliest rsp_valid at T+3; earliest next ready pulse at T+4.
- rsp_data is passed through unmodified. The ALU owns arithmetic and width; the scheduler does no sign or width manipulation.
- Fairness: if both requesters are continuously valid, grants alternate 0,1,0,1,...
- A requester may drop valid before it is granted; it simply loses arbitration for that cycle.

Optional Feature:
ALU_REQ_SCHEDULER_STATS_EN
- Defined: stat_grant0 and stat_grant1 increment on each accepted request from the respective requester. stat_busy increments every cycle the state is not IDLE. All counters saturate at all-ones and clear on reset.
- Undefined: no counter registers exist, and all stat_* outputs are tied to 0.

Test Plan:
1. req0 a=5, b=3, cmd a_en=1, b_en=0, a_op=000; rsp_ready=1 -> alu_en high one cycle; rsp_valid 3 cycles after the ready pulse; rsp_data=8, rsp_id=0, rsp_err=0.
2. After reset, both valid with a=-4, b=2: req0 cmd a_op=001 (SUB), req1 cmd a_en=b_en=1, b_op=11 (B+2) -> first response id=0, data=-6; second response id=1, data=4.
3. req1 a=7, b=1, cmd a_en=b_en=1, b_op=10 (A-1); rsp_ready held low 5 cycles -> rsp_valid, rsp_data=6 and rsp_id=1 stay stable; no ready pulse to either requester until the handshake.
4. req0 cmd a_en=b_en=0 -> alu_en never asserted; rsp_err=1, rsp_data=0, response 1 cycle after the ready pulse.
5. rst_n pulled low during CAPTURE -> next cycle state=IDLE, rsp_valid=0, alu_en=0, rr_ptr=0; a pending req1 is then granted normally.
6. With ALU_REQ_SCHEDULER_STATS_EN, 3 grants to req0 and 2 to req1, each response accepted immediately -> stat_grant0=3, stat_grant1=2, stat_busy=15.
